fetch_ctrl: RTL and testbench

//  Sequences instruction fetch and drives the IF/ID pipeline register inputs each cycle.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 52 +++++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state type for the instruction fetch controller
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FULL,
    S_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry holding register for an instruction acked during a stall
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        pop,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_npc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] npc
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;

  // Clear beats load beats pop; a redirect must never leave a stale entry behind
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      npc_d   = in_npc;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      npc_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign npc   = npc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner, imem req/ack sequencer and IF/ID input driver with stall/flush
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter logic [31:0] PC_STEP   = fetch_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_npc,
  output logic        fetch_valid
);
  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  npc_q, npc_d;
  logic         valid_q, valid_d;

  logic         ack;
  logic [31:0]  addr_inc;
  logic         buf_load, buf_clear, buf_pop;
  logic         buf_valid;
  logic [31:0]  buf_instr, buf_npc;

  // An ack only means something while a request is actually on the bus
  assign ack      = imem_ack & req_q;
  assign addr_inc = addr_q + PC_STEP;

  // Request sequencing: state, bus address and the redirect target (pc)
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (redirect) addr_d = redirect_pc;
      end
      S_RUN: begin
        if (redirect) begin
          if (ack) addr_d = redirect_pc;
          else     state_d = S_DROP;
        end else if (ack) begin
          addr_d = addr_inc;
          if (stall) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect) begin
          addr_d  = redirect_pc;
          state_d = S_RUN;
        end else if (!stall) begin
          state_d = S_RUN;
        end
      end
      S_DROP: begin
        if (ack) begin
          addr_d  = redirect ? redirect_pc : pc_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // pc follows the bus address except while a dropped request is still in flight
    pc_d = pc_q;
    if (redirect)               pc_d = redirect_pc;
    else if (state_q != S_DROP) pc_d = addr_d;

    req_d = (state_d == S_RUN) || (state_d == S_DROP);
  end

  // IF/ID input selection: redirect > stall > skid buffer > fresh ack > bubble
  always_comb begin
    instr_d   = instr_q;
    npc_d     = npc_q;
    valid_d   = valid_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    buf_pop   = 1'b0;
    if (redirect) begin
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      buf_clear = 1'b1;
    end else if (stall) begin
      if (ack && state_q == S_RUN) buf_load = 1'b1;
    end else if (buf_valid) begin
      instr_d = buf_instr;
      npc_d   = buf_npc;
      valid_d = 1'b1;
      buf_pop = 1'b1;
    end else if (ack && state_q == S_RUN) begin
      instr_d = imem_rdata;
      npc_d   = addr_inc;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // All controller state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      npc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .pop      (buf_pop),
    .in_instr (imem_rdata),
    .in_npc   (addr_inc),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .npc      (buf_npc)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign fetch_instr = instr_q;
  assign fetch_npc   = npc_q;
  assign fetch_valid = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl: directed vector table plus random run against a program-order model
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_npc;
  logic        fetch_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_instr (fetch_instr),
    .fetch_npc   (fetch_npc),
    .fetch_valid (fetch_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_npc;
    logic        exp_valid;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic ak, input logic [31:0] rdat, input logic rq,
                              input logic [31:0] ad, input logic [31:0] ins,
                              input logic [31:0] np, input logic vl);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.ack = ak; v.rdata = rdat;
    v.exp_req = rq; v.exp_addr = ad; v.exp_instr = ins; v.exp_npc = np; v.exp_valid = vl;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_instr, prev_npc;
    logic        prev_valid;
    logic        pend;
    logic [31:0] pend_addr;
    int          wait_cnt;
    int          delivered;
    logic [31:0] tmp;

    //          stall redir rpc           ack rdata          req addr           instr          npc           valid
    vecs[0]  = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          NOP,           32'h0,        0); // boot cycle
    vecs[1]  = mk(0, 0, 32'h0,          1, 32'hAAAA_0001,  1, 32'h0,          32'hAAAA_0001, 32'h4,        1);
    vecs[2]  = mk(0, 0, 32'h0,          1, 32'hBBBB_0002,  1, 32'h4,          32'hBBBB_0002, 32'h8,        1);
    vecs[3]  = mk(0, 0, 32'h0,          1, 32'hCCCC_0003,  1, 32'h8,          32'hCCCC_0003, 32'hC,        1);
    vecs[4]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'hC,          NOP,           32'hC,        0); // wait states
    vecs[5]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'hC,          NOP,           32'hC,        0);
    vecs[6]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'hC,          NOP,           32'hC,        0);
    vecs[7]  = mk(0, 0, 32'h0,          1, 32'hDDDD_0004,  1, 32'hC,          32'hDDDD_0004, 32'h10,       1);
    vecs[8]  = mk(1, 0, 32'h0,          1, 32'hEEEE_0005,  1, 32'h10,         32'hDDDD_0004, 32'h10,       1); // stall + ack -> skid
    vecs[9]  = mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h14,         32'hDDDD_0004, 32'h10,       1);
    vecs[10] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h14,         32'hEEEE_0005, 32'h14,       1); // pop skid
    vecs[11] = mk(0, 1, 32'h100,        0, 32'h0,          1, 32'h14,         NOP,           32'h14,       0); // redirect, req outstanding
    vecs[12] = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h14,         NOP,           32'h14,       0);
    vecs[13] = mk(0, 0, 32'h0,          1, 32'hDEAD_BEEF,  1, 32'h14,         NOP,           32'h14,       0); // dropped data
    vecs[14] = mk(0, 0, 32'h0,          1, 32'hF0F0_0006,  1, 32'h100,        32'hF0F0_0006, 32'h104,      1);
    vecs[15] = mk(1, 0, 32'h0,          1, 32'h6060_0007,  1, 32'h104,        32'hF0F0_0006, 32'h104,      1); // fill skid
    vecs[16] = mk(1, 1, 32'hFFFF_FFFC,  0, 32'h0,          0, 32'h108,        NOP,           32'h104,      0); // redirect+stall, buffer full
    vecs[17] = mk(0, 0, 32'h0,          1, 32'h7070_0008,  1, 32'hFFFF_FFFC,  32'h7070_0008, 32'h0,        1); // wrap
    vecs[18] = mk(0, 0, 32'h0,          1, 32'h8080_0009,  1, 32'h0,          32'h8080_0009, 32'h4,        1);
    vecs[19] = mk(0, 1, 32'h200,        1, 32'h9090_000A,  1, 32'h4,          NOP,           32'h4,        0); // redirect with ack
    vecs[20] = mk(0, 0, 32'h0,          1, 32'hA0A0_000B,  1, 32'h200,        32'hA0A0_000B, 32'h204,      1);

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req",   {31'b0, imem_req},    32'h0);
    chk("reset addr",  imem_addr,            32'h0);
    chk("reset instr", fetch_instr,          NOP);
    chk("reset npc",   fetch_npc,            32'h0);
    chk("reset valid", {31'b0, fetch_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      chk($sformatf("v%0d req", i),  {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d addr", i), imem_addr,         vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d instr", i), fetch_instr,          vecs[i].exp_instr);
      chk($sformatf("v%0d npc", i),   fetch_npc,            vecs[i].exp_npc);
      chk($sformatf("v%0d valid", i), {31'b0, fetch_valid}, {31'b0, vecs[i].exp_valid});
      @(negedge clk);
    end

    // Reset asserted mid-cycle with a request outstanding
    stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    chk("pre-reset req", {31'b0, imem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async req",   {31'b0, imem_req},    32'h0);
    chk("async addr",  imem_addr,            32'h0);
    chk("async instr", fetch_instr,          NOP);
    chk("async npc",   fetch_npc,            32'h0);
    chk("async valid", {31'b0, fetch_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("boot req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("run req",  {31'b0, imem_req}, 32'h1);
    chk("run addr", imem_addr,         32'h0);

    // Random run: delivered instructions must follow program order from the last redirect
    exp_pc = 32'h0; pend = 1'b0; pend_addr = 32'h0; wait_cnt = 0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pend) begin
        chk($sformatf("r%0d hold req", c),  {31'b0, imem_req}, 32'h1);
        chk($sformatf("r%0d hold addr", c), imem_addr,         pend_addr);
      end
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      tmp = $urandom;
      tmp[1:0] = 2'b00;
      redirect_pc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : tmp;
      if (imem_req && wait_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = $urandom_range(0, 3);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req && wait_cnt > 0) wait_cnt--;
      end
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
      prev_instr = fetch_instr; prev_npc = fetch_npc; prev_valid = fetch_valid;
      @(posedge clk);
      #1;
      if (redirect) begin
        chk($sformatf("r%0d flush valid", c), {31'b0, fetch_valid}, 32'h0);
        chk($sformatf("r%0d flush instr", c), fetch_instr,          NOP);
        exp_pc = redirect_pc;
      end else if (stall) begin
        chk($sformatf("r%0d stall instr", c), fetch_instr,          prev_instr);
        chk($sformatf("r%0d stall npc", c),   fetch_npc,            prev_npc);
        chk($sformatf("r%0d stall valid", c), {31'b0, fetch_valid}, {31'b0, prev_valid});
      end else if (fetch_valid) begin
        chk($sformatf("r%0d instr", c), fetch_instr, mem_word(exp_pc));
        chk($sformatf("r%0d npc", c),   fetch_npc,   exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        chk($sformatf("r%0d bubble", c), fetch_instr, NOP);
      end
      @(negedge clk);
    end
    total++;
    if (delivered < 300) begin
      bad++;
      $display("FAIL throughput: delivered %0d want >= 300", delivered);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
